iddr_deser: RTL and testbench

- Parametrised multi-lane deserialiser that sits directly behind per-pin input DDR registers.
- Each clock it takes one rise/fall bit pair per lane and assembles RATIO-bit parallel words.
- Word alignment is adjustable per lane, either by manual bitslip or by an automatic training-pattern search.
- Feeds link-layer logic; replaces ad-hoc per-interface shift registers.

---
 rtl/iddr_deser_pkg.sv | 16 +
 rtl/iddr_deser_align.sv | 77 +++++++
 rtl/iddr_deser.sv | 98 +++++++++
 tb/tb_iddr_deser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/iddr_deser_pkg.sv
// Shared types and elaboration helpers for the multi-lane IDDR deserialiser.
package iddr_deser_pkg;

  typedef enum logic [2:0] {
    IDLE, CHECK, SLIP, WAIT, LOCKED, FAILED
  } align_state_t;

  function automatic int off_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  function automatic bit ratio_ok(input int ratio);
    return (ratio >= 4) && (ratio <= 16) && (ratio % 2 == 0);
  endfunction

endpackage

// File: rtl/iddr_deser_align.sv
// Per-lane word-alignment FSM and offset register (manual bitslip + training search).
module iddr_deser_align
  import iddr_deser_pkg::*;
#(
  parameter int               RATIO         = 8,
  parameter logic [RATIO-1:0] TRAIN_PATTERN = RATIO'(8'hB8),
  parameter int               LOCK_COUNT    = 16
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    align_start,
  input  logic                    bitslip,
  input  logic                    word_valid,
  input  logic [RATIO-1:0]        word,
  output logic [off_w(RATIO)-1:0] offset,
  output logic                    aligned,
  output logic                    lane_done,
  output logic                    lane_fail
);
  localparam int OW = off_w(RATIO);
  localparam int SW = $clog2(RATIO + 1);

  align_state_t  state_q;
  logic [OW-1:0] offset_q;
  logic [SW-1:0] slips_q;
  logic [7:0]    match_q;
  logic          aligned_q;
  logic [OW-1:0] offset_inc;

  assign offset_inc = (offset_q == OW'(RATIO - 1)) ? '0 : offset_q + OW'(1);

  // align_start beats any bitslip arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      offset_q  <= '0;
      slips_q   <= '0;
      match_q   <= '0;
      aligned_q <= 1'b0;
    end else if (align_start) begin
      state_q   <= CHECK;
      slips_q   <= '0;
      match_q   <= '0;
      aligned_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, LOCKED, FAILED: if (bitslip) offset_q <= offset_inc;
        CHECK: if (word_valid) begin
          if (word == TRAIN_PATTERN) begin
            match_q <= match_q + 8'd1;
            if (match_q == 8'(LOCK_COUNT - 1)) begin
              state_q   <= LOCKED;
              aligned_q <= 1'b1;
            end
          end else begin
            match_q <= '0;
            state_q <= SLIP;
          end
        end
        SLIP: begin
          offset_q <= offset_inc;
          slips_q  <= slips_q + SW'(1);
          state_q  <= (slips_q == SW'(RATIO - 1)) ? FAILED : WAIT;
        end
        // The word after a slip may straddle the old offset; drop it.
        WAIT:    if (word_valid) state_q <= CHECK;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign offset    = offset_q;
  assign aligned   = aligned_q;
  assign lane_done = (state_q == LOCKED) || (state_q == FAILED);
  assign lane_fail = (state_q == FAILED);

endmodule

// File: rtl/iddr_deser.sv
// Multi-lane deserialiser: per-lane 2*RATIO shift register, shared word phase, per-lane alignment.
module iddr_deser
  import iddr_deser_pkg::*;
#(
  parameter int               LANES         = 4,
  parameter int               RATIO         = 8,
  parameter logic [RATIO-1:0] TRAIN_PATTERN = RATIO'(8'hB8),
  parameter int               LOCK_COUNT    = 16
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       d_rise,
  input  logic [LANES-1:0]       d_fall,
  input  logic [LANES-1:0]       bitslip,
  input  logic                   align_start,
  output logic [LANES*RATIO-1:0] q,
  output logic                   q_valid,
  output logic [LANES-1:0]       aligned,
  output logic                   align_done,
  output logic                   align_fail
);
  localparam int HALF = RATIO / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int OW   = off_w(RATIO);

  if (!ratio_ok(RATIO)) begin : g_bad_ratio
    $error("iddr_deser: RATIO must be even and within 4..16");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_lock
    $error("iddr_deser: LOCK_COUNT must be within 1..255");
  end

  logic [LANES-1:0][2*RATIO-1:0] sr_q, sr_d;
  logic [LANES-1:0][RATIO-1:0]   q_q, q_d;
  logic [PW-1:0]                 phase_q, phase_d;
  logic                          q_valid_q, q_valid_d;
  logic                          done_q, done_d, fail_q, fail_d;
  logic                          capture;
  logic [LANES-1:0][OW-1:0]      offset;
  logic [LANES-1:0]              lane_done, lane_fail;

  // Window taps sr_d so the capture includes this cycle's bit pair.
  always_comb begin
    capture   = (phase_q == PW'(HALF - 1));
    phase_d   = capture ? '0 : phase_q + PW'(1);
    q_d       = q_q;
    q_valid_d = capture;
    done_d    = &lane_done;
    fail_d    = |lane_fail;
    for (int n = 0; n < LANES; n++) begin
      sr_d[n] = {sr_q[n][2*RATIO-3:0], d_rise[n], d_fall[n]};
      if (capture) q_d[n] = sr_d[n][offset[n] +: RATIO];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      q_q       <= '0;
      phase_q   <= '0;
      q_valid_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      q_q       <= q_d;
      phase_q   <= phase_d;
      q_valid_q <= q_valid_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    iddr_deser_align #(
      .RATIO         (RATIO),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_COUNT    (LOCK_COUNT)
    ) u_align (
      .clk         (clk),
      .rst         (rst),
      .align_start (align_start),
      .bitslip     (bitslip[n]),
      .word_valid  (q_valid_q),
      .word        (q_q[n]),
      .offset      (offset[n]),
      .aligned     (aligned[n]),
      .lane_done   (lane_done[n]),
      .lane_fail   (lane_fail[n])
    );
  end

  assign q          = q_q;
  assign q_valid    = q_valid_q;
  assign align_done = done_q;
  assign align_fail = fail_q;

endmodule

// File: tb/tb_iddr_deser.sv
// Randomised bench for iddr_deser with a bit-history / word-level reference model.
module tb_iddr_deser;
  localparam int L = 2, R = 8, H = R / 2, LC = 4;
  localparam logic [7:0] TP = 8'hB8;
  localparam int MI = 0, MT = 1, ML = 2, MF = 3;

  logic clk = 1'b0, rst = 1'b1, align_start = 1'b0;
  logic [L-1:0] d_rise = '0, d_fall = '0, bitslip = '0;
  logic [L*R-1:0] q;
  logic q_valid, align_done, align_fail;
  logic [L-1:0] aligned;

  iddr_deser #(.LANES(L), .RATIO(R), .TRAIN_PATTERN(TP), .LOCK_COUNT(LC)) dut (
    .clk(clk), .rst(rst), .d_rise(d_rise), .d_fall(d_fall), .bitslip(bitslip),
    .align_start(align_start), .q(q), .q_valid(q_valid), .aligned(aligned),
    .align_done(align_done), .align_fail(align_fail));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Serial history (oldest first); word at offset k ends k bits before the newest bit.
  logic [L-1:0] hq[$];
  int mode[L], mat[L], slp[L], disc[L], pend[L], m_off[L];
  logic [7:0] m_q[L];
  logic [L-1:0] m_al;
  logic m_qv, m_done, m_fail, m_ok = 1'b0;
  int cnt;

  function automatic logic [7:0] win(input int l, input int k);
    logic [7:0] w;
    int idx;
    for (int j = 0; j < R; j++) begin
      idx = hq.size() - 1 - k - j;
      w[j] = (idx >= 0) ? hq[idx][l] : 1'b0;
    end
    return w;
  endfunction

  always @(posedge clk) begin
    logic [7:0] nw[L];
    logic cap, nd, nf;
    if (rst) begin
      hq.delete();
      cnt = 0; m_qv = 0; m_done = 0; m_fail = 0; m_al = '0;
      for (int l = 0; l < L; l++) begin
        m_q[l] = '0; mode[l] = MI; mat[l] = 0; slp[l] = 0; disc[l] = 0; pend[l] = 0; m_off[l] = 0;
      end
      m_ok = 1'b1;
    end else begin
      nd = 1'b1; nf = 1'b0;
      for (int l = 0; l < L; l++) begin
        nd &= (mode[l] == ML || mode[l] == MF);
        nf |= (mode[l] == MF);
      end
      hq.push_back(d_rise);
      hq.push_back(d_fall);
      while (hq.size() > 64) void'(hq.pop_front());
      cap = ((cnt % H) == H - 1);
      cnt++;
      for (int l = 0; l < L; l++) nw[l] = win(l, m_off[l]);
      for (int l = 0; l < L; l++) begin
        if (align_start) begin
          mode[l] = MT; mat[l] = 0; slp[l] = 0; disc[l] = 0; pend[l] = 0; m_al[l] = 1'b0;
        end else if (mode[l] != MT) begin
          if (bitslip[l]) m_off[l] = (m_off[l] + 1) % R;
        end else if (pend[l] != 0) begin
          pend[l] = 0; m_off[l] = (m_off[l] + 1) % R; slp[l]++;
          if (slp[l] == R) mode[l] = MF; else disc[l] = 1;
        end else if (m_qv) begin
          if (disc[l] != 0) disc[l] = 0;
          else if (m_q[l] == TP) begin
            mat[l]++;
            if (mat[l] == LC) begin mode[l] = ML; m_al[l] = 1'b1; end
          end else begin
            mat[l] = 0; pend[l] = 1;
          end
        end
      end
      if (cap) for (int l = 0; l < L; l++) m_q[l] = nw[l];
      m_qv = cap; m_done = nd; m_fail = nf;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("q", q, {m_q[1], m_q[0]});
      chk("q_valid", q_valid, m_qv);
      chk("aligned", aligned, m_al);
      chk("align_done", align_done, m_done);
      chk("align_fail", align_fail, m_fail);
    end
  end

  // ---------------- stimulus ----------------
  int gmode[L], gskew[L], bitcnt = 0;

  function automatic logic gen_bit(input int l, input int b);
    case (gmode[l])
      0:       return TP[7 - ((b + 8 - gskew[l]) % 8)];
      1:       return 1'b0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Drive on the falling edge, then sample just after the next rising edge.
  task automatic cyc(input logic [L-1:0] bs = '0, input logic as_ = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    rst = r; bitslip = bs; align_start = as_;
    for (int l = 0; l < L; l++) begin
      d_rise[l] = r ? 1'($urandom_range(0, 1)) : gen_bit(l, bitcnt);
      d_fall[l] = r ? 1'($urandom_range(0, 1)) : gen_bit(l, bitcnt + 1);
    end
    bitcnt = r ? 0 : bitcnt + 2;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_qv(input string nm);
    int n = 0;
    do begin cyc(); n++; end while (!q_valid && n < 20);
    if (!q_valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int first, nqv, n;
    logic [L-1:0] bs;

    // Reset with random data
    gmode = '{2, 2}; gskew = '{0, 0};
    repeat (3) begin
      cyc('0, 1'b0, 1'b1);
      chk("rst_q", q, 0); chk("rst_qv", q_valid, 0);
      chk("rst_aligned", aligned, 0); chk("rst_done", align_done, 0);
    end
    gmode = '{0, 0};
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (q_valid && first == 0) first = i;
    end
    chk("first_qv_cycle", first, 4);

    // Aligned stream on both lanes
    nqv = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (q_valid) begin nqv++; chk("aligned_word", q, 16'hB8B8); end
    end
    chk("qv_period", nqv, 4);

    // Manual slip: lane0 needs offset 3
    cyc('0, 1'b0, 1'b1);
    gskew = '{5, 0};
    wait_qv("slip_pre");
    repeat (3) cyc(2'b01);
    wait_qv("slip_post");
    chk("slip_lane0", q[7:0], 8'hB8);
    chk("slip_lane1", q[15:8], 8'hB8);

    // Auto align: lane0 needs offset 5
    cyc('0, 1'b0, 1'b1);
    gskew = '{3, 0};
    repeat (2) cyc();
    cyc('0, 1'b1);
    n = 0;
    while (aligned != 2'b11 && n < 300) begin cyc(); n++; end
    chk("auto_aligned", aligned, 2'b11);
    repeat (2) cyc();
    chk("auto_done", align_done, 1); chk("auto_fail", align_fail, 0);
    chk("model_off0", m_off[0], 5); chk("model_slips0", slp[0], 5);
    wait_qv("auto_word");
    chk("auto_word", q, 16'hB8B8);

    // Fail: lane0 stuck at 0
    cyc('0, 1'b0, 1'b1);
    gmode = '{1, 0}; gskew = '{0, 0};
    repeat (2) cyc();
    cyc('0, 1'b1);
    n = 0;
    while (!align_done && n < 300) begin cyc(); n++; end
    chk("fail_done", align_done, 1); chk("fail_flag", align_fail, 1);
    chk("fail_aligned", aligned, 2'b10);
    cyc('0, 1'b1);
    repeat (3) cyc();
    chk("restart_fail_clr", align_fail, 0); chk("restart_done_clr", align_done, 0);

    // Reset while lane0 discards a word after a slip
    cyc('0, 1'b0, 1'b1);
    gmode = '{0, 0}; gskew = '{3, 0};
    cyc('0, 1'b1);
    n = 0;
    while (!(mode[0] == MT && disc[0] == 1) && n < 100) begin cyc(); n++; end
    chk("reached_wait", disc[0], 1);
    cyc('0, 1'b0, 1'b1);
    chk("midrst_q", q, 0); chk("midrst_qv", q_valid, 0);
    chk("midrst_aligned", aligned, 0); chk("midrst_done", align_done, 0);
    chk("midrst_off0", m_off[0], 0);
    repeat (5) cyc(2'b01);
    wait_qv("midrst_word");
    chk("midrst_slip_lane0", q[7:0], 8'hB8);

    // Random rounds: random skews/data, random slips, occasional restarts
    for (int rd = 0; rd < 6; rd++) begin
      cyc('0, 1'b0, 1'b1);
      for (int l = 0; l < L; l++) begin
        gmode[l] = ($urandom_range(0, 3) == 0) ? 2 : 0;
        gskew[l] = $urandom_range(0, 7);
      end
      cyc('0, 1'b1);
      for (int i = 0; i < 150; i++) begin
        for (int l = 0; l < L; l++) bs[l] = ($urandom_range(0, 7) == 0);
        cyc(bs, $urandom_range(0, 60) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
